// File: rtl/mips_run_ctrl.sv
// Run controller for the multicycle MIPS core: reset sequencing, clock-enable gating,
// halt/timeout completion detection and a show-ahead trace FIFO of retired {pc, instr}.
module mips_run_ctrl #(
    parameter int                 ADDR_W     = 32,
    parameter int                 DATA_W     = 32,
    parameter int                 RST_CYCLES = 3,
    parameter int                 DEPTH      = 16,
    parameter int                 CNT_W      = 32,
    parameter int unsigned        TIMEOUT    = 100000,
    parameter logic [DATA_W-1:0]  HALT_INSTR = DATA_W'(32'h1000_FFFF)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         retire,
    input  logic [ADDR_W-1:0]            pc,
    input  logic [DATA_W-1:0]            instr,
    output logic                         core_rst,
    output logic                         core_en,
    output logic [1:0]                   state,
    output logic                         done,
    output logic                         timed_out,
    output logic [CNT_W-1:0]             cycle_cnt,
    output logic [CNT_W-1:0]             instr_cnt,
    input  logic                         trace_rd,
    output logic                         trace_valid,
    output logic [ADDR_W-1:0]            trace_pc,
    output logic [DATA_W-1:0]            trace_instr,
    output logic [$clog2(DEPTH+1)-1:0]   trace_count,
    output logic                         trace_ovf
);

    localparam int                RCW       = $clog2(RST_CYCLES + 1);
    localparam logic [RCW-1:0]    RST_LAST  = RCW'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam int                PW        = $clog2(DEPTH);
    localparam int                CW        = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]     FULL_C    = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_RUN     = 2'd1,
        ST_HALT    = 2'd2,
        ST_TIMEOUT = 2'd3
    } run_state_e;

    run_state_e      state_q, state_d;
    logic [RCW-1:0]  rst_cnt_q, rst_cnt_d;
    logic            run;
    logic            halt_hit;
    logic [CNT_W-1:0] cycle_inc;
    logic [CNT_W-1:0] instr_inc;

    assign run       = (state_q == ST_RUN);
    assign halt_hit  = run && retire && (instr == HALT_INSTR);
    assign cycle_inc = (&cycle_cnt) ? cycle_cnt : cycle_cnt + 1'b1;
    assign instr_inc = (&instr_cnt) ? instr_cnt : instr_cnt + 1'b1;
    assign state     = state_q;

    // ------------------------------------------------------------------
    // Run-state FSM
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        unique case (state_q)
            ST_RESET: begin
                if (rst_cnt_q == RST_LAST) state_d = ST_RUN;
                else                       rst_cnt_d = rst_cnt_q + 1'b1;
            end
            ST_RUN: begin
                // Halt takes priority when the budget runs out on the same edge.
                if (halt_hit)                      state_d = ST_HALT;
                else if (cycle_inc == TIMEOUT_C)   state_d = ST_TIMEOUT;
            end
            default: ;
        endcase
    end

    // Core controls are registered from the next state so they switch with the state.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q   <= ST_RESET;
            rst_cnt_q <= '0;
            core_rst  <= 1'b1;
            core_en   <= 1'b0;
            done      <= 1'b0;
            timed_out <= 1'b0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            core_rst  <= (state_d == ST_RESET);
            core_en   <= (state_d == ST_RUN);
            done      <= (state_d == ST_HALT) || (state_d == ST_TIMEOUT);
            timed_out <= (state_d == ST_TIMEOUT);
        end
    end

    // ------------------------------------------------------------------
    // Saturating run counters, frozen outside RUN
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else if (run) begin
            cycle_cnt <= cycle_inc;
            if (retire) instr_cnt <= instr_inc;
        end
    end

    // ------------------------------------------------------------------
    // Trace FIFO (show-ahead)
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] mem_pc    [DEPTH];
    logic [DATA_W-1:0] mem_instr [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic              wr_req, full, do_push, do_pop, drop;

    assign wr_req  = run && retire;
    assign full    = (trace_count == FULL_C);
    assign do_pop  = trace_rd && trace_valid;
    // A pop frees the slot on the same edge, so a full FIFO still accepts the write.
    assign do_push = wr_req && (!full || do_pop);
    assign drop    = wr_req && full && !do_pop;

    assign trace_valid = (trace_count != '0);
    assign trace_pc    = trace_valid ? mem_pc[rd_ptr]    : '0;
    assign trace_instr = trace_valid ? mem_instr[rd_ptr] : '0;

    // NOTE: storage is not reset; an empty count masks stale entries from the outputs.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_pc[wr_ptr]    <= pc;
            mem_instr[wr_ptr] <= instr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            trace_count <= '0;
            trace_ovf   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   trace_count <= trace_count + 1'b1;
                2'b01:   trace_count <= trace_count - 1'b1;
                default: trace_count <= trace_count;
            endcase
            if (drop) trace_ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Self-checking bench for mips_run_ctrl: directed scenarios plus random runs
// compared against a queue-based behavioural model.
module tb_mips_run_ctrl;

    localparam int          ADDR_W     = 32;
    localparam int          DATA_W     = 32;
    localparam int          RST_CYCLES = 3;
    localparam int          DEPTH      = 8;
    localparam int          CNT_W      = 16;
    localparam int unsigned TIMEOUT    = 30;
    localparam logic [31:0] HALT       = 32'h1000_FFFF;
    localparam int          CW         = $clog2(DEPTH + 1);
    localparam longint      MAXC       = (64'd1 << CNT_W) - 1;

    logic              clk, rst, retire, trace_rd;
    logic [31:0]       pc, instr;
    logic              core_rst, core_en, done, timed_out, trace_valid, trace_ovf;
    logic [1:0]        state;
    logic [CNT_W-1:0]  cycle_cnt, instr_cnt;
    logic [31:0]       trace_pc, trace_instr;
    logic [CW-1:0]     trace_count;

    mips_run_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RST_CYCLES(RST_CYCLES), .DEPTH(DEPTH),
        .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .HALT_INSTR(HALT)
    ) dut (
        .clk(clk), .rst(rst), .retire(retire), .pc(pc), .instr(instr),
        .core_rst(core_rst), .core_en(core_en), .state(state), .done(done),
        .timed_out(timed_out), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt),
        .trace_rd(trace_rd), .trace_valid(trace_valid), .trace_pc(trace_pc),
        .trace_instr(trace_instr), .trace_count(trace_count), .trace_ovf(trace_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase 0=reset sequence, 1=running, 2=halted, 3=timed out
    typedef struct { logic [31:0] pc; logic [31:0] instr; } entry_t;
    entry_t q[$];
    int     m_phase, m_rcnt;
    longint m_cyc, m_ins;
    bit     m_ovf;
    int     total, bad;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_phase = 0; m_rcnt = 0; m_cyc = 0; m_ins = 0; m_ovf = 0;
    endtask

    task automatic model_edge(input bit r, input logic [31:0] p, input logic [31:0] i, input bit rd);
        int  sz;
        bit  pop, wr, halt;
        sz   = q.size();
        pop  = rd && (sz > 0);
        wr   = (m_phase == 1) && r;
        halt = wr && (i == HALT);
        if (pop) void'(q.pop_front());
        if (wr) begin
            if (sz == DEPTH && !pop) m_ovf = 1;
            else                     q.push_back('{pc: p, instr: i});
        end
        case (m_phase)
            0: begin
                m_rcnt++;
                if (m_rcnt == RST_CYCLES) m_phase = 1;
            end
            1: begin
                if (m_cyc < MAXC) m_cyc++;
                if (wr && m_ins < MAXC) m_ins++;
                if (halt)                 m_phase = 2;
                else if (m_cyc == TIMEOUT) m_phase = 3;
            end
            default: ;
        endcase
    endtask

    task automatic check_all(input string tag);
        check({tag, ".state"},     64'(state),       64'(m_phase));
        check({tag, ".core_rst"},  64'(core_rst),    64'(m_phase == 0));
        check({tag, ".core_en"},   64'(core_en),     64'(m_phase == 1));
        check({tag, ".done"},      64'(done),        64'(m_phase >= 2));
        check({tag, ".timed_out"}, 64'(timed_out),   64'(m_phase == 3));
        check({tag, ".cycle_cnt"}, 64'(cycle_cnt),   64'(m_cyc));
        check({tag, ".instr_cnt"}, 64'(instr_cnt),   64'(m_ins));
        check({tag, ".valid"},     64'(trace_valid), 64'(q.size() > 0));
        check({tag, ".count"},     64'(trace_count), 64'(q.size()));
        check({tag, ".ovf"},       64'(trace_ovf),   64'(m_ovf));
        check({tag, ".head_pc"},   64'(trace_pc),    (q.size() > 0) ? 64'(q[0].pc)    : 64'd0);
        check({tag, ".head_ins"},  64'(trace_instr), (q.size() > 0) ? 64'(q[0].instr) : 64'd0);
    endtask

    // Inputs change 1 ns after an edge; outputs are sampled 1 ns after the next edge.
    task automatic step(input bit r, input logic [31:0] p, input logic [31:0] i,
                        input bit rd, input string tag);
        retire = r; pc = p; instr = i; trace_rd = rd;
        @(posedge clk);
        model_edge(r, p, i, rd);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(1'b0, 32'd0, 32'd0, 1'b0, tag);
    endtask

    // Asserts rst mid-cycle, checks the asynchronous clear, and holds it for 25 ns.
    task automatic do_reset(input string tag);
        retire = 1'b0; trace_rd = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        check_all({tag, ".async"});
        #24;
        rst = 1'b0;
    endtask

    task automatic to_run(input string tag);
        for (int g = 0; g < RST_CYCLES + 2 && m_phase == 0; g++) idle(tag);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] v;
        v = $urandom;
        if (v == HALT) v ^= 32'h1;
        return v;
    endfunction

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; retire = 1'b0; trace_rd = 1'b0; pc = '0; instr = '0;
        model_reset();
        #1;

        // Reset sequence
        do_reset("por");
        idle("seq1");
        check("seq1.core_rst_hi", 64'(core_rst), 64'd1);
        idle("seq2");
        check("seq2.core_rst_hi", 64'(core_rst), 64'd1);
        idle("seq3");
        check("seq3.run", 64'(state), 64'd1);
        check("seq3.cyc0", 64'(cycle_cnt), 64'd0);
        idle("seq4");
        check("seq4.cyc1", 64'(cycle_cnt), 64'd1);

        // Normal program ending in the halt instruction
        for (int k = 0; k < 5; k++)
            step(1'b1, 32'h3000 + 32'(4 * k), (k == 4) ? HALT : rand_instr(), 1'b0, "prog");
        check("prog.halted", 64'(state), 64'd2);
        check("prog.icnt", 64'(instr_cnt), 64'd5);
        check("prog.tcnt", 64'(trace_count), 64'd5);
        step(1'b1, 32'h9999, rand_instr(), 1'b0, "prog.ignored");
        for (int k = 0; k < 5; k++) begin
            check("prog.pop_pc", 64'(trace_pc), 64'h3000 + 64'(4 * k));
            step(1'b0, 32'd0, 32'd0, 1'b1, "prog.pop");
        end
        check("prog.drained", 64'(trace_valid), 64'd0);
        step(1'b0, 32'd0, 32'd0, 1'b1, "prog.rd_empty");

        // Timeout with random non-halt traffic
        do_reset("to");
        to_run("to.seq");
        for (int g = 0; g < 2 * TIMEOUT && m_phase == 1; g++)
            step(1'($urandom_range(0, 1)), $urandom, rand_instr(), 1'($urandom_range(0, 1)), "to.run");
        check("to.state", 64'(state), 64'd3);
        check("to.flag", 64'(timed_out), 64'd1);
        check("to.cyc", 64'(cycle_cnt), 64'(TIMEOUT));
        for (int k = 0; k < 3; k++) step(1'b1, $urandom, rand_instr(), 1'b0, "to.frozen");

        // Overflow, then full with simultaneous retire and read
        do_reset("ovf");
        to_run("ovf.seq");
        for (int k = 0; k < DEPTH + 2; k++)
            step(1'b1, 32'h4000 + 32'(4 * k), rand_instr(), 1'b0, "ovf.fill");
        check("ovf.count", 64'(trace_count), 64'(DEPTH));
        check("ovf.flag", 64'(trace_ovf), 64'd1);
        check("ovf.head", 64'(trace_pc), 64'h4000);
        step(1'b1, 32'h5000, rand_instr(), 1'b1, "ovf.rw");
        check("ovf.rw_count", 64'(trace_count), 64'(DEPTH));

        do_reset("full");
        to_run("full.seq");
        for (int k = 0; k < DEPTH; k++)
            step(1'b1, 32'h6000 + 32'(4 * k), rand_instr(), 1'b0, "full.fill");
        step(1'b1, 32'h7000, rand_instr(), 1'b1, "full.rw");
        check("full.no_ovf", 64'(trace_ovf), 64'd0);
        check("full.head", 64'(trace_pc), 64'h6004);
        step(1'b1, 32'h7004, rand_instr(), 1'b1, "full.rw_empty_no");

        // Halt retiring on the edge the budget runs out
        do_reset("sim");
        to_run("sim.seq");
        for (int g = 0; g < 2 * TIMEOUT && m_cyc != TIMEOUT - 1; g++) idle("sim.wait");
        step(1'b1, 32'h8000, HALT, 1'b0, "sim.end");
        check("sim.halt", 64'(state), 64'd2);
        check("sim.no_to", 64'(timed_out), 64'd0);

        // Reset in the middle of a run with queued entries
        do_reset("mid");
        to_run("mid.seq");
        for (int k = 0; k < 7; k++)
            step(1'(k % 2), 32'hA000 + 32'(4 * k), rand_instr(), 1'b0, "mid.run");
        check("mid.queued", 64'(trace_count), 64'd3);
        do_reset("mid.rst");
        check("mid.valid0", 64'(trace_valid), 64'd0);
        to_run("mid.reseq");
        check("mid.rerun", 64'(state), 64'd1);

        // Random runs, including reads after completion and retires during reset
        for (int run_i = 0; run_i < 4; run_i++) begin
            do_reset("rnd");
            for (int k = 0; k < 60; k++)
                step($urandom_range(0, 9) < 6, $urandom,
                     ($urandom_range(0, 19) == 0) ? HALT : rand_instr(),
                     $urandom_range(0, 9) < 4, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
